// File: rtl/ras_resolver_pkg.sv
// ---------------------------------------------------------------------------
// ras_resolver_pkg
// Shared widths, the checkpoint entry type and small helpers for the
// return-address-stack resolver and its checkpoint FIFO.
//   XLEN           : PC / target width
//   RAS_PTR_WIDTH  : RAS stack-pointer width
//   CKPT_DEPTH     : number of in-flight predicted returns (power of 2)
//   CKPT_PTR_WIDTH : FIFO pointer width, one extra bit to tell full from empty
//   CNT_WIDTH      : saturating statistic counter width
// ---------------------------------------------------------------------------
package ras_resolver_pkg;

  localparam int XLEN           = 32;
  localparam int RAS_PTR_WIDTH  = 3;
  localparam int CKPT_DEPTH     = 4;
  localparam int CKPT_PTR_WIDTH = $clog2(CKPT_DEPTH) + 1;
  localparam int CNT_WIDTH      = 16;

  // One in-flight prediction: what fetch guessed and where the RAS pointer
  // stood before the pop, so it can be rolled back on a wrong guess.
  typedef struct packed {
    logic [XLEN-1:0]          target;
    logic [RAS_PTR_WIDTH-1:0] sp;
  } ckpt_entry_t;

  // Outcome of a resolve request in the current cycle.
  typedef enum logic [1:0] {
    RES_NONE,
    RES_HIT,
    RES_MISS,
    RES_ORPHAN
  } res_kind_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  // Stack pointer the RAS holds after popping from a checkpointed pointer;
  // a checkpoint of zero stays at zero rather than wrapping.
  function automatic logic [RAS_PTR_WIDTH-1:0] post_pop_sp(input logic [RAS_PTR_WIDTH-1:0] sp);
    return (sp == '0) ? '0 : sp - 1'b1;
  endfunction

endpackage

// File: rtl/ras_resolver_if.sv
// ---------------------------------------------------------------------------
// ras_resolver_if
// Bundle between fetch/EX (master side) and the resolver (slave side).
//   alloc_valid/alloc_target/alloc_sp/alloc_ready : fetch records a prediction
//   res_valid/res_target                          : EX resolves the oldest one
//   mispredict/redirect_pc                        : fetch redirect request
//   restore_en/restore_sp                         : RAS pointer rollback
//   orphan_err                                    : resolve with nothing in flight
//   hit_count/miss_count                          : saturating statistics
// ---------------------------------------------------------------------------
interface ras_resolver_if;
  import ras_resolver_pkg::*;

  logic                     alloc_valid;
  logic [XLEN-1:0]          alloc_target;
  logic [RAS_PTR_WIDTH-1:0] alloc_sp;
  logic                     alloc_ready;
  logic                     res_valid;
  logic [XLEN-1:0]          res_target;
  logic                     mispredict;
  logic [XLEN-1:0]          redirect_pc;
  logic                     restore_en;
  logic [RAS_PTR_WIDTH-1:0] restore_sp;
  logic                     orphan_err;
  logic [CNT_WIDTH-1:0]     hit_count;
  logic [CNT_WIDTH-1:0]     miss_count;

  modport master (
    output alloc_valid, alloc_target, alloc_sp, res_valid, res_target,
    input  alloc_ready, mispredict, redirect_pc, restore_en, restore_sp,
           orphan_err, hit_count, miss_count
  );

  modport slave (
    input  alloc_valid, alloc_target, alloc_sp, res_valid, res_target,
    output alloc_ready, mispredict, redirect_pc, restore_en, restore_sp,
           orphan_err, hit_count, miss_count
  );

endinterface

// File: rtl/ras_resolver_ckpt_fifo.sv
// ---------------------------------------------------------------------------
// ras_resolver_ckpt_fifo
// Synchronous circular FIFO of in-flight return predictions (the checkpoint
// FIFO). Pointers carry one extra wrap bit; clear empties it in one edge.
// The caller only pushes when there is room and only pops when non-empty.
//   clk, reset   : clock, synchronous active-low reset
//   i_clear      : drop every entry (wins over push/pop)
//   i_push       : write i_push_data at the tail
//   i_pop        : retire the head
//   o_head       : oldest entry
//   o_full/o_empty/o_count : occupancy
// ---------------------------------------------------------------------------
module ras_resolver_ckpt_fifo
  import ras_resolver_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic                      i_push,
  input  ckpt_entry_t               i_push_data,
  input  logic                      i_pop,
  output ckpt_entry_t               o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [CKPT_PTR_WIDTH-1:0] o_count
);

  localparam int IDX_W = CKPT_PTR_WIDTH - 1;

  ckpt_entry_t               r_mem [CKPT_DEPTH];
  logic [CKPT_PTR_WIDTH-1:0] r_wrPtr;
  logic [CKPT_PTR_WIDTH-1:0] r_rdPtr;

  // Full when the wrap bits differ but the slot indices coincide.
  assign o_full  = (r_wrPtr[IDX_W] != r_rdPtr[IDX_W]) &&
                   (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_count = r_wrPtr - r_rdPtr;
  assign o_head  = r_mem[r_rdPtr[IDX_W-1:0]];

  // Pointer bookkeeping; wrap is plain modulo arithmetic on the extra bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Entry storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr[IDX_W-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/ras_resolver.sv
// ---------------------------------------------------------------------------
// ras_resolver
// Tracks every RAS-predicted return between fetch and EX, checks the
// prediction when EX resolves it, and on a wrong target asks fetch to
// redirect and the RAS to roll its stack pointer back.
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   flush  : pipeline flush, discards all in-flight predictions
//   bus    : ras_resolver_if.slave (allocate, resolve, redirect, restore,
//            orphan error and statistics)
// All outputs are registered (one cycle after res_valid) except alloc_ready.
// ---------------------------------------------------------------------------
module ras_resolver
  import ras_resolver_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  ras_resolver_if.slave  bus
);

  ckpt_entry_t               w_head;
  ckpt_entry_t               w_pushData;
  logic                      w_full;
  logic                      w_empty;
  logic [CKPT_PTR_WIDTH-1:0] w_count;
  res_kind_t                 w_resKind;
  logic                      w_clear;
  logic                      w_pop;
  logic                      w_room;
  logic                      w_push;

  logic                      r_mispredict;
  logic [XLEN-1:0]           r_redirectPc;
  logic                      r_restoreEn;
  logic [RAS_PTR_WIDTH-1:0]  r_restoreSp;
  logic                      r_orphanErr;
  logic [CNT_WIDTH-1:0]      r_hitCount;
  logic [CNT_WIDTH-1:0]      r_missCount;

  // Classify this cycle's resolve against the oldest prediction.
  always_comb begin
    w_resKind = RES_NONE;
    if (bus.res_valid) begin
      if (w_empty)
        w_resKind = RES_ORPHAN;
      else if (bus.res_target == w_head.target)
        w_resKind = RES_HIT;
      else
        w_resKind = RES_MISS;
    end
  end

  // A miss makes every younger prediction wrong-path, so it empties the
  // FIFO exactly like a flush, including any allocation in the same cycle.
  assign w_clear = flush || (w_resKind == RES_MISS);
  assign w_pop   = (w_resKind == RES_HIT) && !flush;

  // A slot is available if we are below capacity or the head leaves on
  // this edge, which keeps alloc+resolve legal while full.
  assign w_room  = (w_count != CKPT_PTR_WIDTH'(CKPT_DEPTH)) || w_pop;
  assign w_push  = bus.alloc_valid && w_room && !w_clear;

  assign w_pushData.target = bus.alloc_target;
  assign w_pushData.sp     = bus.alloc_sp;

  ras_resolver_ckpt_fifo u_ckptFifo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_push_data (w_pushData),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Pulses default low every cycle so none can stretch; redirect_pc and
  // restore_sp hold their last value between mispredicts. A flush
  // suppresses anything resolved in the same cycle but leaves counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mispredict <= 1'b0;
      r_redirectPc <= '0;
      r_restoreEn  <= 1'b0;
      r_restoreSp  <= '0;
      r_orphanErr  <= 1'b0;
      r_hitCount   <= '0;
      r_missCount  <= '0;
    end else begin
      r_mispredict <= 1'b0;
      r_restoreEn  <= 1'b0;
      r_orphanErr  <= 1'b0;
      if (!flush) begin
        case (w_resKind)
          RES_HIT: begin
            r_hitCount <= sat_inc(r_hitCount);
          end
          RES_MISS: begin
            r_mispredict <= 1'b1;
            r_redirectPc <= bus.res_target;
            r_restoreEn  <= 1'b1;
            r_restoreSp  <= post_pop_sp(w_head.sp);
            r_missCount  <= sat_inc(r_missCount);
          end
          RES_ORPHAN: begin
            r_orphanErr <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.alloc_ready = !w_full;
  assign bus.mispredict  = r_mispredict;
  assign bus.redirect_pc = r_redirectPc;
  assign bus.restore_en  = r_restoreEn;
  assign bus.restore_sp  = r_restoreSp;
  assign bus.orphan_err  = r_orphanErr;
  assign bus.hit_count   = r_hitCount;
  assign bus.miss_count  = r_missCount;

endmodule

// File: tb/tb_ras_resolver.sv
// ---------------------------------------------------------------------------
// tb_ras_resolver
// Directed scenarios for ras_resolver: reset, hit, miss/rollback, full FIFO,
// flush and hit-counter saturation. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point after the following edge.
// ---------------------------------------------------------------------------
module tb_ras_resolver;
  import ras_resolver_pkg::*;

  logic clk;
  logic reset;
  logic flush;
  int   total;
  int   bad;

  ras_resolver_if rifc ();

  ras_resolver u_dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (rifc.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic alloc_one(input logic [XLEN-1:0] t, input logic [RAS_PTR_WIDTH-1:0] sp);
    rifc.alloc_valid  = 1'b1;
    rifc.alloc_target = t;
    rifc.alloc_sp     = sp;
    cycle();
    rifc.alloc_valid  = 1'b0;
  endtask

  task automatic resolve(input logic [XLEN-1:0] t);
    rifc.res_valid  = 1'b1;
    rifc.res_target = t;
    cycle();
    rifc.res_valid  = 1'b0;
  endtask

  // Two allocations then reset: everything back to idle, FIFO empty.
  task automatic test_reset();
    alloc_one(32'h0000_0A00, 3'd1);
    alloc_one(32'h0000_0B00, 3'd2);
    do_reset();
    total++; if (rifc.alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_alloc_ready got=%b want=1", rifc.alloc_ready); end
    total++; if (rifc.hit_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_hit got=%h want=0", rifc.hit_count); end
    total++; if (rifc.miss_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_miss got=%h want=0", rifc.miss_count); end
    total++; if (rifc.redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_redirect got=%h want=0", rifc.redirect_pc); end
    total++; if ({rifc.mispredict, rifc.restore_en, rifc.orphan_err, rifc.restore_sp} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_pulses got=%b%b%b sp=%0d want=000 sp=0", rifc.mispredict, rifc.restore_en, rifc.orphan_err, rifc.restore_sp);
    end
    resolve(32'h0000_1234);
    total++; if (rifc.orphan_err !== 1'b1) begin bad++; $display("[TB] FAIL reset_orphan got=%b want=1", rifc.orphan_err); end
    total++; if (rifc.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL orphan_no_mispredict got=%b want=0", rifc.mispredict); end
    cycle();
    total++; if (rifc.orphan_err !== 1'b0) begin bad++; $display("[TB] FAIL orphan_pulse_width got=%b want=0", rifc.orphan_err); end
  endtask

  // Correct prediction: counted as a hit, no redirect.
  task automatic test_hit();
    alloc_one(32'h0000_1004, 3'd2);
    resolve(32'h0000_1004);
    total++; if (rifc.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL hit_mispredict got=%b want=0", rifc.mispredict); end
    total++; if (rifc.restore_en !== 1'b0) begin bad++; $display("[TB] FAIL hit_restore got=%b want=0", rifc.restore_en); end
    total++; if (rifc.hit_count !== 16'd1) begin bad++; $display("[TB] FAIL hit_count got=%0d want=1", rifc.hit_count); end
    total++; if (rifc.miss_count !== 16'd0) begin bad++; $display("[TB] FAIL hit_miss_count got=%0d want=0", rifc.miss_count); end
  endtask

  // Wrong prediction: redirect, rollback, younger entry discarded; then a
  // checkpoint of zero must restore to zero.
  task automatic test_miss();
    alloc_one(32'h0000_1004, 3'd3);
    alloc_one(32'h0000_2008, 3'd2);
    resolve(32'h0000_1010);
    total++; if (rifc.mispredict !== 1'b1) begin bad++; $display("[TB] FAIL miss_pulse got=%b want=1", rifc.mispredict); end
    total++; if (rifc.redirect_pc !== 32'h0000_1010) begin bad++; $display("[TB] FAIL miss_redirect got=%h want=00001010", rifc.redirect_pc); end
    total++; if (rifc.restore_en !== 1'b1) begin bad++; $display("[TB] FAIL miss_restore_en got=%b want=1", rifc.restore_en); end
    total++; if (rifc.restore_sp !== 3'd2) begin bad++; $display("[TB] FAIL miss_restore_sp got=%0d want=2", rifc.restore_sp); end
    total++; if (rifc.miss_count !== 16'd1) begin bad++; $display("[TB] FAIL miss_count got=%0d want=1", rifc.miss_count); end
    cycle();
    total++; if ({rifc.mispredict, rifc.restore_en} !== 2'b00) begin bad++; $display("[TB] FAIL miss_pulse_width got=%b%b want=00", rifc.mispredict, rifc.restore_en); end
    resolve(32'h0000_2008);
    total++; if (rifc.orphan_err !== 1'b1) begin bad++; $display("[TB] FAIL miss_fifo_cleared got=%b want=1", rifc.orphan_err); end
    total++; if (rifc.hit_count !== 16'd1) begin bad++; $display("[TB] FAIL miss_hit_unchanged got=%0d want=1", rifc.hit_count); end
    alloc_one(32'h0000_3000, 3'd0);
    resolve(32'h0000_3004);
    total++; if (rifc.restore_sp !== 3'd0) begin bad++; $display("[TB] FAIL sp0_restore got=%0d want=0", rifc.restore_sp); end
    total++; if (rifc.redirect_pc !== 32'h0000_3004) begin bad++; $display("[TB] FAIL sp0_redirect got=%h want=00003004", rifc.redirect_pc); end
    total++; if (rifc.miss_count !== 16'd2) begin bad++; $display("[TB] FAIL sp0_miss_count got=%0d want=2", rifc.miss_count); end
  endtask

  // Fill to capacity, drop an extra alloc, then alloc+resolve while full.
  task automatic test_full();
    logic [XLEN-1:0] drainTargets [4];
    drainTargets[0] = 32'h0000_0104;
    drainTargets[1] = 32'h0000_0108;
    drainTargets[2] = 32'h0000_010C;
    drainTargets[3] = 32'h0000_0500;
    for (int i = 0; i < 4; i++) alloc_one(32'h0000_0100 + 32'(4 * i), 3'(i + 1));
    total++; if (rifc.alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b want=0", rifc.alloc_ready); end
    alloc_one(32'h0000_0999, 3'd7);
    rifc.alloc_valid  = 1'b1;
    rifc.alloc_target = 32'h0000_0500;
    rifc.alloc_sp     = 3'd5;
    resolve(32'h0000_0100);
    rifc.alloc_valid  = 1'b0;
    total++; if (rifc.alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_same_cycle_count got=%b want=0", rifc.alloc_ready); end
    total++; if (rifc.hit_count !== 16'd2) begin bad++; $display("[TB] FAIL full_same_cycle_hit got=%0d want=2", rifc.hit_count); end
    for (int i = 0; i < 4; i++) begin
      resolve(drainTargets[i]);
      total++; if (rifc.mispredict !== 1'b0) begin bad++; $display("[TB] FAIL full_drain_%0d mispredict got=%b want=0", i, rifc.mispredict); end
    end
    total++; if (rifc.hit_count !== 16'd6) begin bad++; $display("[TB] FAIL full_drain_hits got=%0d want=6", rifc.hit_count); end
    total++; if (rifc.alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_drained_ready got=%b want=1", rifc.alloc_ready); end
  endtask

  // Flush with a same-cycle wrong resolve and alloc: nothing reported,
  // FIFO emptied, statistics kept.
  task automatic test_flush();
    for (int i = 0; i < 3; i++) alloc_one(32'h0000_0600 + 32'(4 * i), 3'(i + 1));
    flush             = 1'b1;
    rifc.alloc_valid  = 1'b1;
    rifc.alloc_target = 32'h0000_0700;
    rifc.alloc_sp     = 3'd4;
    resolve(32'h0000_DEAD);
    flush             = 1'b0;
    rifc.alloc_valid  = 1'b0;
    total++; if ({rifc.mispredict, rifc.restore_en, rifc.orphan_err} !== 3'b000) begin
      bad++; $display("[TB] FAIL flush_pulses got=%b%b%b want=000", rifc.mispredict, rifc.restore_en, rifc.orphan_err);
    end
    total++; if (rifc.hit_count !== 16'd6 || rifc.miss_count !== 16'd2) begin
      bad++; $display("[TB] FAIL flush_counters got=%0d/%0d want=6/2", rifc.hit_count, rifc.miss_count);
    end
    resolve(32'h0000_0600);
    total++; if (rifc.orphan_err !== 1'b1) begin bad++; $display("[TB] FAIL flush_emptied got=%b want=1", rifc.orphan_err); end
  endtask

  // 65535 hits reach all-ones; one more hit must not wrap.
  task automatic test_saturation();
    do_reset();
    rifc.alloc_valid  = 1'b1;
    rifc.alloc_target = 32'h0000_0040;
    rifc.alloc_sp     = 3'd1;
    cycle();
    rifc.res_valid    = 1'b1;
    rifc.res_target   = 32'h0000_0040;
    for (int i = 0; i < 65535; i++) cycle();
    total++; if (rifc.hit_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_preload got=%h want=ffff", rifc.hit_count); end
    cycle();
    rifc.res_valid    = 1'b0;
    rifc.alloc_valid  = 1'b0;
    total++; if (rifc.hit_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold got=%h want=ffff", rifc.hit_count); end
    total++; if (rifc.miss_count !== 16'h0) begin bad++; $display("[TB] FAIL sat_miss got=%h want=0", rifc.miss_count); end
  endtask

  // Run the scenarios in order and report.
  initial begin
    clk               = 1'b0;
    reset             = 1'b0;
    flush             = 1'b0;
    total             = 0;
    bad               = 0;
    rifc.alloc_valid  = 1'b0;
    rifc.alloc_target = '0;
    rifc.alloc_sp     = '0;
    rifc.res_valid    = 1'b0;
    rifc.res_target   = '0;
    cycle();
    do_reset();
    test_reset();
    test_hit();
    test_miss();
    test_full();
    test_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
